// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared constants and state encoding for the multiply issue
//               controller and the execute-stage multiplier interface.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  // Operand and product width of the sequential Booth multiplier
  localparam int c_OPERAND_W = 32;

  // Default destination-register tag width
  localparam int c_TAG_W_DEFAULT = 5;

  // Default watchdog limit; must cover the 32-cycle multiply plus margin
  localparam int c_TIMEOUT_CYCLES_DEFAULT = 40;

  // Default watchdog counter width; 2**c_CNT_W_DEFAULT > c_TIMEOUT_CYCLES_DEFAULT
  localparam int c_CNT_W_DEFAULT = 6;

  // Issue controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } mult_state_e;

endpackage
`default_nettype wire

// File: rtl/cycle_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : cycle_watchdog
// Description : Clearable, enabled up-counter that flags when it has reached
//               a fixed terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_watchdog #(
  parameter int CNT_W    = 6,
  parameter int TERMINAL = 39
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; clear has priority over enable
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue_ctrl
// Description : Issue/collect controller in front of the sequential Booth
//               multiplier. Accepts a tagged request, starts the multiplier,
//               waits for done (with watchdog and flush abort) and returns a
//               tagged response while stalling the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int TAG_W          = c_TAG_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = c_CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [c_OPERAND_W-1:0] req_a,
  input  logic [c_OPERAND_W-1:0] req_b,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic                   flush,
  output logic [c_OPERAND_W-1:0] mult_mc,
  output logic [c_OPERAND_W-1:0] mult_mp,
  output logic                   mult_start,
  output logic                   mult_reset,
  input  logic [c_OPERAND_W-1:0] mult_prod,
  input  logic                   mult_overflow,
  input  logic                   mult_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [c_OPERAND_W-1:0] rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_ovf,
  output logic                   rsp_timeout,
  output logic                   stall
);

  mult_state_e            r_state;
  logic [c_OPERAND_W-1:0] r_op_a;
  logic [c_OPERAND_W-1:0] r_op_b;
  logic [TAG_W-1:0]       r_op_tag;
  logic                   r_mult_start;
  logic                   r_mult_reset;
  logic                   r_rsp_valid;
  logic [c_OPERAND_W-1:0] r_rsp_data;
  logic [TAG_W-1:0]       r_rsp_tag;
  logic                   r_rsp_ovf;
  logic                   r_rsp_timeout;

  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_terminal;

  // Watchdog restarts while the start pulse is out and runs only in BUSY
  assign w_wd_clear  = (r_state == ST_START);
  assign w_wd_enable = (r_state == ST_BUSY);

  cycle_watchdog #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_wd_clear),
    .i_enable   (w_wd_enable),
    .o_terminal (w_wd_terminal)
  );

  // Control FSM with registered multiplier strobes and response fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_op_tag      <= '0;
      r_mult_start  <= 1'b0;
      r_mult_reset  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
      r_rsp_ovf     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      r_mult_start <= 1'b0;
      r_mult_reset <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A flush in the same cycle blocks acceptance
          if (req_valid && !flush) begin
            r_op_a       <= req_a;
            r_op_b       <= req_b;
            r_op_tag     <= req_tag;
            r_mult_start <= 1'b1;
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          if (flush) begin
            r_mult_reset <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Flush cancels; done beats a coincident watchdog expiry
          if (flush) begin
            r_mult_reset <= 1'b1;
            r_state      <= ST_IDLE;
          end else if (mult_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= mult_prod;
            r_rsp_tag     <= r_op_tag;
            r_rsp_ovf     <= mult_overflow;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESP;
          end else if (w_wd_terminal) begin
            r_mult_reset  <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_tag     <= r_op_tag;
            r_rsp_ovf     <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Result is committed; flush has no effect here
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE) && !flush;
  assign stall       = (r_state != ST_IDLE);
  assign mult_mc     = r_op_a;
  assign mult_mp     = r_op_b;
  assign mult_start  = r_mult_start;
  assign mult_reset  = r_mult_reset;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_ovf     = r_rsp_ovf;
  assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_issue_ctrl
// Description : Self-checking bench for mult_issue_ctrl with a stub
//               multiplier and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_issue_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic [31:0]      mult_mc;
  logic [31:0]      mult_mp;
  logic             mult_start;
  logic             mult_reset;
  logic [31:0]      mult_prod;
  logic             mult_overflow;
  logic             mult_done;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_ovf;
  logic             rsp_timeout;
  logic             stall;

  always #5 clk = ~clk;

  mult_issue_ctrl #(
    .TAG_W          (TAG_W),
    .TIMEOUT_CYCLES (40),
    .CNT_W          (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_tag       (req_tag),
    .flush         (flush),
    .mult_mc       (mult_mc),
    .mult_mp       (mult_mp),
    .mult_start    (mult_start),
    .mult_reset    (mult_reset),
    .mult_prod     (mult_prod),
    .mult_overflow (mult_overflow),
    .mult_done     (mult_done),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .rsp_ovf       (rsp_ovf),
    .rsp_timeout   (rsp_timeout),
    .stall         (stall)
  );

  // ---------------- stub multiplier: done N cycles after start (0 = never)
  int                 stub_lat = 32;
  int                 stub_cnt = 0;
  logic [31:0]        stub_prod = '0;
  logic               stub_ovf = 1'b0;
  logic               stub_done = 1'b0;
  logic signed [63:0] stub_full;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (mult_start) begin
      stub_full = {{32{mult_mc[31]}}, mult_mc} * {{32{mult_mp[31]}}, mult_mp};
      stub_prod <= stub_full[31:0];
      stub_ovf  <= !((&stub_full[63:31]) || !(|stub_full[63:31]));
      stub_cnt  <= (stub_lat > 1) ? stub_lat - 1 : 0;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
  end

  assign mult_done     = stub_done;
  assign mult_prod     = stub_done ? stub_prod : 32'hDEAD_BEEF;
  assign mult_overflow = stub_done ? stub_ovf : 1'b1;

  // ---------------- scoreboard
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic             to;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_mreset = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every accepted response against the oldest pending expectation
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got response data 0x%0h tag %0d, expected none", rsp_data, rsp_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_tag", rsp_tag, mon_e.tag);
        check("rsp_ovf", rsp_ovf, mon_e.ovf);
        check("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
  end

  always @(negedge clk) if (mult_reset) n_mreset++;

  // ---------------- helpers (inputs change at posedge + 1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [TAG_W-1:0] tag, input logic ovf, input logic to);
    rsp_t e;
    e.data = d;
    e.tag  = tag;
    e.ovf  = ovf;
    e.to   = to;
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(input int max, output int cyc, output logic stall_drop);
    cyc        = 0;
    stall_drop = 1'b0;
    while (!rsp_valid && cyc < max) begin
      if (!stall) stall_drop = 1'b1;
      tick();
      cyc++;
    end
    if (!rsp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_rsp: rsp_valid still 0 after %0d cycles, expected 1", cyc);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_rsp_valid", rsp_valid, 0);
    check("post_hs_stall", stall, 0);
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", req_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_mult_start", mult_start, 0);
    check("rst_mult_reset", mult_reset, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_mult_mc", mult_mc, 0);
    check("rst_mult_mp", mult_mp, 0);
  endtask

  // ---------------- vectors
  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      d;
    logic             ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int   cyc;
    logic sd;
    int   n0;
    logic bad;

    vecs[0] = '{32'd7,        32'd6,        5'd3,  32'd42,       1'b0};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1, 1'b0};
    vecs[2] = '{32'h40000000, 32'd4,        5'd7,  32'h00000000, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'd1,        1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'd2,        5'd10, 32'hFFFFFFFE, 1'b1};
    vecs[5] = '{32'h80000000, 32'd1,        5'd0,  32'h80000000, 1'b0};
    vecs[6] = '{32'h00010000, 32'h00010000, 5'd17, 32'h00000000, 1'b1};

    // Reset
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_state();
    tick();

    // Table-driven normal operations, done 32 cycles after start
    stub_lat = 32;
    for (int i = 0; i < 7; i++) begin
      check("idle_req_ready", req_ready, 1);
      push_exp(vecs[i].d, vecs[i].tag, vecs[i].ovf, 1'b0);
      issue(vecs[i].a, vecs[i].b, vecs[i].tag);
      check("start_pulse", mult_start, 1);
      check("stall_after_accept", stall, 1);
      tick();
      check("start_one_cycle", mult_start, 0);
      check("busy_mult_mc", mult_mc, vecs[i].a);
      check("busy_mult_mp", mult_mp, vecs[i].b);
      wait_rsp(100, cyc, sd);
      check("done_to_valid_latency", cyc, 32);
      check("stall_held", sd, 0);
      consume();
      tick();
    end

    // Watchdog timeout: stub never completes
    stub_lat = 0;
    n0 = n_mreset;
    push_exp(32'd0, 5'd12, 1'b0, 1'b1);
    issue(32'd9, 32'd9, 5'd12);
    tick();
    wait_rsp(100, cyc, sd);
    check("timeout_latency", cyc, 40);
    check("timeout_mult_reset", mult_reset, 1);
    consume();
    check("timeout_mult_reset_off", mult_reset, 0);
    check("timeout_mreset_count", n_mreset - n0, 1);
    tick();

    // Flush on the 10th BUSY cycle; late done must be ignored
    stub_lat = 32;
    n0 = n_mreset;
    issue(32'd11, 32'd13, 5'd5);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", stall, 0);
    check("flush_mult_reset", mult_reset, 1);
    check("flush_no_rsp", rsp_valid, 0);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rsp_valid || stall) bad = 1'b1;
    end
    check("flush_late_done_ignored", bad, 0);
    check("flush_mreset_count", n_mreset - n0, 1);

    // Flush in IDLE blocks acceptance
    req_a = 32'd1; req_b = 32'd1; req_tag = 5'd1;
    req_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("idle_flush_req_ready", req_ready, 0);
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    check("idle_flush_not_accepted", stall, 0);
    check("idle_flush_no_start", mult_start, 0);
    tick();

    // Back-pressure in RESP with a second request waiting
    push_exp(32'h00012340, 5'd20, 1'b0, 1'b0);
    issue(32'h00001234, 32'h10, 5'd20);
    wait_rsp(100, cyc, sd);
    push_exp(32'd25, 5'd21, 1'b0, 1'b0);
    req_a = 32'd5; req_b = 32'd5; req_tag = 5'd21;
    req_valid = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!rsp_valid || rsp_data !== 32'h00012340 || req_ready || mult_start) bad = 1'b1;
      tick();
    end
    check("bp_stable_no_accept", bad, 0);
    check("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_req_ready", req_ready, 1);
    check("bp_idle_no_start", mult_start, 0);
    tick();
    req_valid = 1'b0;
    check("bp_second_start", mult_start, 1);
    wait_rsp(100, cyc, sd);
    consume();
    tick();

    // Flush during RESP is ignored
    push_exp(32'd42, 5'd3, 1'b0, 1'b0);
    issue(32'd7, 32'd6, 5'd3);
    wait_rsp(100, cyc, sd);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("resp_flush_ignored", rsp_valid, 1);
    consume();
    tick();

    // Reset during BUSY, then a fresh operation
    n0 = n_mreset;
    issue(32'd100, 32'd100, 5'd8);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();
    check("reset_no_mreset", n_mreset - n0, 0);
    push_exp(32'd6, 5'd2, 1'b0, 1'b0);
    issue(32'd2, 32'd3, 5'd2);
    wait_rsp(100, cyc, sd);
    consume();
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
